// File: rtl/prog_loader.sv
// prog_loader: serial boot loader. Receives an image over an 8N1 UART line
// (length byte, payload bytes, optional checksum byte) and writes the payload
// into a RAM starting at address 0x00 while holding the CPU in reset.
//
// Optional feature: define LOADER_CHECKSUM_EN to add a trailing checksum byte
// (8-bit sum of the payload) that must match before the CPU is released.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   rx        asynchronous serial input, idle high, LSB first
//   ram_addr  RAM write address (payload byte index)
//   ram_data  RAM write data
//   ram_we    one-cycle RAM write strobe
//   cpu_hold  high while the CPU must stay halted
//   done      sticky, image loaded successfully
//   err       sticky, framing or checksum failure
module prog_loader #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_data,
  output logic       ram_we,
  output logic       cpu_hold,
  output logic       done,
  output logic       err
);

  localparam logic [7:0] HALF_M1 = 8'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0] FULL_M1 = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    L_IDLE, L_LEN, L_DATA,
`ifdef LOADER_CHECKSUM_EN
    L_CSUM,
`endif
    L_DONE, L_ERROR
  } ld_state_t;

  logic       rx_meta, rx_sync;
  rx_state_t  rx_st, rx_nxt;
  logic [7:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] rx_byte;
  logic       byte_valid, frame_err;
  logic       sample_pt;

  ld_state_t  st, st_nxt;
  logic [7:0] index, len_m1;
  logic [7:0] addr_q, data_q;
  logic       wr;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] acc;
`endif

  // Sample point: mid-start re-check in START, end of each bit period after that.
  assign sample_pt = (rx_st == RX_START) ? (cnt == HALF_M1) : (cnt == FULL_M1);

  // Receiver next state
  always_comb begin
    rx_nxt = rx_st;
    case (rx_st)
      RX_IDLE:  if (!rx_sync) rx_nxt = RX_START;
      RX_START: if (sample_pt) rx_nxt = rx_sync ? RX_IDLE : RX_BITS;
      RX_BITS:  if (sample_pt && bit_cnt == 3'd7) rx_nxt = RX_STOP;
      RX_STOP:  if (sample_pt) rx_nxt = RX_IDLE;
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  // Receiver registers: synchronizer, bit timing, shift register, byte strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_st      <= RX_IDLE;
      cnt        <= 8'd0;
      bit_cnt    <= 3'd0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_st      <= rx_nxt;
      cnt        <= (rx_st == RX_IDLE || sample_pt) ? 8'd0 : cnt + 8'd1;
      if (rx_st == RX_START)
        bit_cnt <= 3'd0;
      else if (rx_st == RX_BITS && sample_pt)
        bit_cnt <= bit_cnt + 3'd1;
      byte_valid <= (rx_st == RX_STOP) && sample_pt && rx_sync;
      frame_err  <= (rx_st == RX_STOP) && sample_pt && !rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_st == RX_BITS && sample_pt)
      shift <= {rx_sync, shift[7:1]};
    if (rx_st == RX_STOP && sample_pt)
      rx_byte <= shift;
  end

  // Loader next state and write decision
  always_comb begin
    st_nxt = st;
    wr     = 1'b0;
    case (st)
      L_IDLE: st_nxt = L_LEN;
      L_LEN: begin
        if (frame_err)       st_nxt = L_ERROR;
        else if (byte_valid) st_nxt = L_DATA;
      end
      L_DATA: begin
        if (frame_err) st_nxt = L_ERROR;
        else if (byte_valid) begin
          wr = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          if (index == len_m1) st_nxt = L_CSUM;
`else
          if (index == len_m1) st_nxt = L_DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      L_CSUM: begin
        if (frame_err)       st_nxt = L_ERROR;
        else if (byte_valid) st_nxt = (rx_byte == acc) ? L_DONE : L_ERROR;
      end
`endif
      default: st_nxt = st;
    endcase
  end

  // Loader registers; len_m1 wraps so a length byte of 0 gives 0xFF (256 bytes)
  always_ff @(posedge clk) begin
    if (reset) begin
      st     <= L_IDLE;
      index  <= 8'd0;
      addr_q <= 8'd0;
      data_q <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
      acc    <= 8'd0;
`endif
    end else begin
      st <= st_nxt;
      if (wr) begin
        index  <= index + 8'd1;
        addr_q <= index;
        data_q <= rx_byte;
`ifdef LOADER_CHECKSUM_EN
        acc    <= acc + rx_byte;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (st == L_LEN && byte_valid)
      len_m1 <= 8'(rx_byte - 8'd1);
  end

  // Write is presented in the byte_valid cycle; between writes the last values hold.
  assign ram_we   = wr && !reset;
  assign ram_addr = ram_we ? index : addr_q;
  assign ram_data = ram_we ? rx_byte : data_q;
  assign cpu_hold = (st != L_DONE);
  assign done     = (st == L_DONE);
  assign err      = (st == L_ERROR);

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] ram_addr, ram_data;
  logic       ram_we, cpu_hold, done, err;

  always #5 clk = ~clk;

  prog_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: logs every strobe, flags multi-cycle strobes and drifting outputs.
  logic [15:0] wr_q[$];
  int          hold_bad = 0;
  int          we_bad = 0;
  logic [7:0]  last_a = 8'd0, last_d = 8'd0;
  bit          prev_we = 1'b0, rst_seen = 1'b1;

  always @(negedge clk) begin
    if (reset) begin
      rst_seen = 1'b1;
      prev_we  = 1'b0;
    end else begin
      if (rst_seen) begin
        last_a = 8'd0; last_d = 8'd0; rst_seen = 1'b0;
      end
      if (ram_we) begin
        if (prev_we) we_bad++;
        wr_q.push_back({ram_addr, ram_data});
        last_a = ram_addr; last_d = ram_data;
      end else if (ram_addr !== last_a || ram_data !== last_d) begin
        hold_bad++;
      end
      prev_we = ram_we;
    end
  end

  logic [7:0] pl[$];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    wr_q.delete();
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  // Sends length, payload in pl, and (if enabled) a good or corrupted checksum,
  // then compares the logged writes and flags with what the image should produce.
  task automatic run_image(input string tag, input logic [7:0] len_b, input bit good_csum);
    logic [7:0] sum;
    bit         exp_done;
    sum = 8'd0;
    foreach (pl[i]) sum = sum + pl[i];
    send_byte(len_b, 1'b1);
    foreach (pl[i]) send_byte(pl[i], 1'b1);
    exp_done = 1'b1;
`ifdef LOADER_CHECKSUM_EN
    send_byte(good_csum ? sum : sum ^ 8'h01, 1'b1);
    exp_done = good_csum;
`endif
    repeat (CPB) @(negedge clk);
    check({tag, " nwrites"}, wr_q.size(), pl.size());
    for (int i = 0; i < pl.size(); i++)
      check({tag, " write"}, (i < wr_q.size()) ? {16'd0, wr_q[i]} : 32'hDEAD_0000,
            {16'd0, 8'(i), pl[i]});
    check({tag, " done"}, done, exp_done);
    check({tag, " err"}, err, !exp_done);
    check({tag, " cpu_hold"}, cpu_hold, !exp_done);
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst ram_addr", ram_addr, 8'h00);
    check("rst ram_data", ram_data, 8'h00);
    check("rst ram_we", ram_we, 1'b0);
    check("rst cpu_hold", cpu_hold, 1'b1);
    check("rst done", done, 1'b0);
    check("rst err", err, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Fixed three-byte image
    pl = '{8'hA1, 8'hB2, 8'hC3};
    run_image("img3", 8'h03, 1'b1);

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    pl = '{8'h10, 8'h20};
    run_image("csum_ok", 8'h02, 1'b1);
    do_reset();
    run_image("csum_bad", 8'h02, 1'b0);
`endif

    // Randomized images
    for (int k = 0; k < 4; k++) begin
      int n;
      do_reset();
      n = $urandom_range(1, 20);
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      run_image("rand", 8'(n), bit'($urandom_range(0, 1)));
    end

    // Framing error on second data byte
    do_reset();
    send_byte(8'h03, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    repeat (CPB) @(negedge clk);
    check("ferr err", err, 1'b1);
    check("ferr done", done, 1'b0);
    check("ferr cpu_hold", cpu_hold, 1'b1);
    check("ferr nwrites", wr_q.size(), 1);
    check("ferr write0", (wr_q.size() > 0) ? {16'd0, wr_q[0]} : 32'hDEAD_0000, 32'h0000_0011);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    repeat (CPB) @(negedge clk);
    check("ferr stuck err", err, 1'b1);
    check("ferr stuck nwrites", wr_q.size(), 1);

    // Short glitch while idle, then reset in the middle of the second byte
    do_reset();
    repeat (20) @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch err", err, 1'b0);
    check("glitch nwrites", wr_q.size(), 0);
    send_byte(8'h04, 1'b1);
    send_byte(8'h5A, 1'b1);
    rx = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    do_reset();
    repeat (2 * CPB) @(negedge clk);
    check("midrst nwrites", wr_q.size(), 0);
    check("midrst err", err, 1'b0);
    pl = '{8'h01, 8'h00, 8'hFE};
    run_image("reload", 8'h03, 1'b1);

    // Full 256-byte image, then a trailing byte after done
    do_reset();
    pl.delete();
    for (int i = 0; i < 256; i++) pl.push_back(8'(i));
    run_image("img256", 8'h00, 1'b1);
    send_byte(8'h55, 1'b1);
    repeat (CPB) @(negedge clk);
    check("after_done nwrites", wr_q.size(), 256);
    check("after_done ram_addr", ram_addr, 8'hFF);
    check("after_done ram_data", ram_data, 8'hFF);
    check("after_done ram_we", ram_we, 1'b0);
    check("after_done done", done, 1'b1);

    check("we one cycle", we_bad, 0);
    check("addr/data hold", hold_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range 4..255.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rx  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-005 ram_addr  output  8  RAM write address, which is the index of the current payload byte.
REQ-006 ram_data  output  8  RAM write data.
REQ-007 ram_we  output  1  one-cycle RAM write strobe.
REQ-008 cpu_hold  output  1  holds the CPU in reset/halt while high.
REQ-009 done  output  1  sticky flag; image loaded successfully.
REQ-010 err  output  1  sticky flag; framing or checksum failure.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-012 Receiver SHALL detect a start bit on synchronized rx low while the receiver is idle.
REQ-013 Receiver SHALL re-check the start bit at CLKS_PER_BIT/2 and return to idle without error if rx is high there (glitch).
REQ-014 Receiver SHALL sample each data bit and the stop bit every CLKS_PER_BIT cycles after the mid-start sample.
REQ-015 A stop bit sampled low SHALL be a framing error: the byte is discarded and the FSM enters ERROR.
REQ-016 A valid byte SHALL raise an internal byte_valid for exactly one cycle, the cycle after the stop sample.
REQ-017 The loader FSM SHALL have the states IDLE, LEN, DATA, CSUM, DONE and ERROR.
REQ-018 IDLE SHALL move to LEN unconditionally on the first cycle after reset.
REQ-019 In LEN, the first valid byte SHALL be the payload length N; N=0 means 256; the FSM then goes to DATA.
REQ-020 In DATA, each valid byte SHALL drive ram_data=byte, ram_addr=index and ram_we=1 for one cycle (the byte_valid cycle).
REQ-021 In DATA, the index SHALL start at 0x00 and increment after each write.
REQ-022 After the Nth write the FSM SHALL go to CSUM if LOADER_CHECKSUM_EN is defined, otherwise to DONE.
REQ-023 Index SHALL never wrap: N=256 writes addresses 0x00..0xFF exactly once, then leaves DATA.
REQ-024 In DONE, done=1 and cpu_hold=0; further rx bytes SHALL be received but ignored, with no ram_we.
REQ-025 In ERROR, err=1 and cpu_hold=1; ERROR and DONE are exited only by reset.
REQ-026 ram_we SHALL be 0 in every state except DATA.
REQ-027 ram_addr and ram_data SHALL hold their last values between writes.
REQ-028 Length and checksum bytes SHALL never produce ram_we.

Reset
REQ-029 On reset: FSM=IDLE, receiver idle, index=0, checksum accumulator=0.
REQ-030 On reset: ram_addr=0x00, ram_data=0x00, ram_we=0, cpu_hold=1, done=0, err=0.
REQ-031 Reset mid-byte or mid-image SHALL discard partial data, with no write in the reset cycle or the cycle after.

Configuration
REQ-032 With LOADER_CHECKSUM_EN defined: an 8-bit accumulator SHALL sum (mod 256) all N payload bytes.
REQ-033 With LOADER_CHECKSUM_EN defined: in CSUM, the next valid byte SHALL be compared to the sum; equal goes to DONE, unequal goes to ERROR.
REQ-034 Without LOADER_CHECKSUM_EN: the CSUM state and accumulator SHALL be absent, and DONE follows the last payload byte directly.

Verification (CLKS_PER_BIT=16)
REQ-035 Checksum off; send 0x03,0xA1,0xB2,0xC3 -> writes (00,A1),(01,B2),(02,C3), each ram_we one cycle; then done=1, cpu_hold=0, err=0.
REQ-036 Checksum on; send 0x02,0x10,0x20,0x30 -> two writes, done=1; repeat after reset with 0x31 as the last byte -> err=1, done=0, cpu_hold=1.
REQ-037 Checksum off; send 0x00 then 256 bytes of value i -> addresses 0x00..0xFF written with value i, no 257th write, done=1.
REQ-038 Second data byte sent with stop bit low -> err=1, exactly one ram_we observed, FSM stuck until reset.
REQ-039 rx low pulse of 4 cycles while idle -> no byte and no err; assert reset mid-second-byte, then resend a full image -> loads from address 0x00 correctly.
REQ-040 After done=1, send 0x55 -> ram_we stays 0, and ram_addr/ram_data unchanged.
